// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detect, edge/bit counters, phase enables and
// the per-frame data_valid / frame_err verdict pulse.
module uart_rx_ctrl (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic [5:0] Prescale,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic [4:0] edge_cnt,
   output logic [3:0] bit_cnt,
   output logic       dat_samp_en,
   output logic       strt_chk_en,
   output logic       deser_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       data_valid,
   output logic       frame_err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t     state;
   logic [5:0] p_lat;
   logic       par_flag;
   logic       bit_end;

   function automatic logic [5:0] clamp_p(input logic [5:0] v);
      if (v < 6'd4)
         return 6'd4;
      else if (v > 6'd32)
         return 6'd32;
      else
         return v;
   endfunction

   // Checkers are registered one cycle ahead, so their flags are consumed here.
   assign bit_end = (state != IDLE) && ({1'b0, edge_cnt} == (p_lat - 6'd1));

   assign dat_samp_en = (state != IDLE);
   assign strt_chk_en = (state == START);
   assign deser_en    = (state == DATA);
   assign par_chk_en  = (state == PARITY);
   assign stp_chk_en  = (state == STOP);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         edge_cnt   <= 5'd0;
         bit_cnt    <= 4'd0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         par_flag   <= 1'b0;
         p_lat      <= 6'd32;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (state == IDLE) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
            if (!RX_IN) begin
               state <= START;
               p_lat <= clamp_p(Prescale);
            end
         end else if (!bit_end) begin
            edge_cnt <= edge_cnt + 5'd1;
         end else begin
            edge_cnt <= 5'd0;
            bit_cnt  <= bit_cnt + 4'd1;
            case (state)
               START: begin
                  if (strt_glitch) begin
                     state   <= IDLE;
                     bit_cnt <= 4'd0;
                  end else begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (bit_cnt == 4'd8)
                     state <= PAR_EN ? PARITY : STOP;
               end
               PARITY: begin
                  par_flag <= par_err;
                  state    <= STOP;
               end
               STOP: begin
                  if (!stp_err && !par_flag)
                     data_valid <= 1'b1;
                  else
                     frame_err <= 1'b1;
                  state    <= IDLE;
                  bit_cnt  <= 4'd0;
                  par_flag <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
